// File: rtl/ghash_accumulator_pkg.sv
// Shared GCM definitions: field width, reduction constant and GHASH FSM state encoding.
package ghash_accumulator_pkg;

    // Field / block width of GF(2^128)
    localparam int NB_DATA  = 128;

    // Default width of the per-message block counter
    localparam int NB_COUNT = 32;

    // Reduction constant in GCM bit order (bit 127 is the x^0 coefficient)
    localparam logic [127:0] R_X = {8'he1, 120'd0};

    // Multiplicative identity in GCM bit order
    localparam logic [127:0] GF_ONE = {1'b1, 127'd0};

    // GHASH framing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/ghash_accumulator_gf_mult.sv
// Combinational GF(2^128) multiplier in GCM bit order (shift-and-add, right shifts).
module gf_2to128_multiplier
    import ghash_accumulator_pkg::*;
#(
    parameter int NB_DATA = 128
) (
    input  logic [NB_DATA-1:0] a,
    input  logic [NB_DATA-1:0] b,
    output logic [NB_DATA-1:0] product
);

    localparam logic [NB_DATA-1:0] R_POLY = NB_DATA'(R_X);

    logic [NB_DATA-1:0] z;
    logic [NB_DATA-1:0] v;

    // Walk the bits of a from x^0 (MSB) upward, adding b*x^i and reducing by R on each shift
    always_comb begin
        z = '0;
        v = b;
        for (int i = 0; i < NB_DATA; i++) begin
            if (a[NB_DATA-1-i]) begin
                z = z ^ v;
            end
            if (v[0]) begin
                v = (v >> 1) ^ R_POLY;
            end else begin
                v = v >> 1;
            end
        end
        product = z;
    end

endmodule

// File: rtl/ghash_accumulator.sv
// Sequential GHASH accumulator: Y_i = (Y_{i-1} ^ X_i) * H, tag presented via valid/ready.
module ghash_accumulator
    import ghash_accumulator_pkg::*;
#(
    parameter int NB_DATA  = ghash_accumulator_pkg::NB_DATA,
    parameter int NB_COUNT = ghash_accumulator_pkg::NB_COUNT
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [NB_DATA-1:0]  i_h_key,
    input  logic                i_h_key_load,
    input  logic                i_valid,
    input  logic [NB_DATA-1:0]  i_data,
    input  logic                i_sop,
    input  logic                i_eop,
    output logic                o_ready,
    output logic                o_tag_valid,
    output logic [NB_DATA-1:0]  o_tag,
    input  logic                i_tag_ready,
    output logic [NB_COUNT-1:0] o_block_count,
    output logic                o_sop_err
);

    // Only the 128-bit field is supported
    localparam bit BAD_CONF = (NB_DATA != 128);

    if (BAD_CONF) begin : g_bad_conf
        $error("ghash_accumulator: NB_DATA must be 128");
    end

    state_t              state;
    state_t              state_next;

    logic [NB_DATA-1:0]  y;
    logic [NB_DATA-1:0]  h;
    logic [NB_COUNT-1:0] count;
    logic                sop_err;

    logic                accept;
    logic                restart;
    logic                tag_taken;
    logic [NB_DATA-1:0]  mult_a;
    logic [NB_DATA-1:0]  mult_p;

    // Handshake qualifiers; a new message starts from IDLE or from an sop inside ACCUM
    always_comb begin
        accept    = i_valid & o_ready;
        restart   = (state == ST_IDLE) | i_sop;
        tag_taken = (state == ST_HOLD) & i_tag_ready;
    end

    // Multiplier operand: X alone on a message start, Y^X when continuing
    always_comb begin
        mult_a = restart ? i_data : (y ^ i_data);
    end

    gf_2to128_multiplier #(
        .NB_DATA (NB_DATA)
    ) u_gf_mult (
        .a       (mult_a),
        .b       (h),
        .product (mult_p)
    );

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = i_eop ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept && i_eop) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_tag_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        o_ready       = (state != ST_HOLD);
        o_tag_valid   = (state == ST_HOLD);
        o_tag         = y;
        o_block_count = count;
        o_sop_err     = sop_err;
    end

    // Accumulator: loaded from the multiplier on each accepted block, cleared once the tag is taken
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            y <= '0;
        end else if (accept) begin
            y <= mult_p;
        end else if (tag_taken) begin
            y <= '0;
        end
    end

    // Hash subkey: only writable between messages; a block accepted this cycle still sees the old value
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            h <= '0;
        end else if ((state == ST_IDLE) && i_h_key_load) begin
            h <= i_h_key;
        end
    end

    // Block counter: restarts at 1 on a message start, saturates at all-ones
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count <= '0;
        end else if (accept) begin
            if (restart) begin
                count <= NB_COUNT'(1);
            end else if (!(&count)) begin
                count <= count + NB_COUNT'(1);
            end
        end else if (tag_taken) begin
            count <= '0;
        end
    end

    // Restart error: single-cycle pulse for an sop accepted in the middle of a message
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sop_err <= 1'b0;
        end else begin
            sop_err <= accept & (state == ST_ACCUM) & i_sop;
        end
    end

endmodule
